// File: rtl/ppu_vga_pkg.sv
// Shared definitions for the PPU scanline reader: state encoding, VGA geometry defaults and
// ring-buffer address layout.
package ppu_vga_pkg;

  localparam int unsigned PIX_W   = 5;
  localparam int unsigned LINE_W  = 5;
  localparam int unsigned COL_W   = 8;
  localparam int unsigned ADDR_W  = LINE_W + COL_W;
  localparam int unsigned COORD_W = 10;

  localparam int unsigned      DEF_H_OFFSET = 64;
  localparam int unsigned      DEF_ACTIVE_W = 512;
  localparam int unsigned      DEF_ACTIVE_H = 480;
  localparam logic [PIX_W-1:0] DEF_BACKDROP = 5'h00;

  typedef enum logic [1:0] {
    S_BLANK = 2'd0,
    S_FETCH = 2'd1,
    S_UNDER = 2'd2
  } state_e;

  // Per-pixel tag that travels alongside the buffer read.
  typedef struct packed {
    logic valid;
    logic use_ram;
    logic y0;
  } pix_tag_t;

  function automatic logic [ADDR_W-1:0] buf_addr(input logic [LINE_W-1:0] line,
                                                 input logic [COL_W-1:0]  col);
    return {line, col};
  endfunction

endpackage

// File: rtl/ppu_line_reader_dly.sv
// Tag delay line plus output register: RAM_LAT tag stages line up with returning buffer data,
// the final stage registers pix_index/pix_valid. Honours PPU_LINE_READER_SCANLINES_EN.
module ppu_line_reader_dly
  import ppu_vga_pkg::*;
#(
  parameter int unsigned      RAM_LAT  = 1,
  parameter logic [PIX_W-1:0] BACKDROP = DEF_BACKDROP
) (
  input  logic             clock,
  input  logic             reset,
  input  pix_tag_t         tag_in,
  input  logic [PIX_W-1:0] rd_data,
  output logic [PIX_W-1:0] pix_index,
  output logic             pix_valid
);

  pix_tag_t [RAM_LAT-1:0] tag_q;
  pix_tag_t               tag_out;
  logic [PIX_W-1:0]       ram_idx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < int'(RAM_LAT); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[RAM_LAT-1];

`ifdef PPU_LINE_READER_SCANLINES_EN
  // Odd row of each NES line pair shows the darkened palette row.
  always_comb begin
    ram_idx = rd_data;
    if (tag_out.y0) begin
      ram_idx = {2'b00, rd_data[2:0]};
    end
  end
`else
  logic unused_y0;
  assign unused_y0 = tag_out.y0;

  always_comb begin
    ram_idx = rd_data;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pix_index <= BACKDROP;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= tag_out.valid;
      if (tag_out.valid) begin
        pix_index <= tag_out.use_ram ? ram_idx : BACKDROP;
      end
    end
  end

endmodule

// File: rtl/ppu_line_reader.sv
// Read side of the PPU scanline ring buffer: 2x upscale, centring, line-ready tracking and
// backdrop substitution. Optional darkened scanlines via PPU_LINE_READER_SCANLINES_EN.
module ppu_line_reader
  import ppu_vga_pkg::*;
#(
  parameter int unsigned      H_OFFSET = DEF_H_OFFSET,
  parameter int unsigned      ACTIVE_W = DEF_ACTIVE_W,
  parameter int unsigned      ACTIVE_H = DEF_ACTIVE_H,
  parameter int unsigned      RAM_LAT  = 1,
  parameter logic [PIX_W-1:0] BACKDROP = DEF_BACKDROP
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pix_ce,
  input  logic [COORD_W-1:0] x_addr,
  input  logic [COORD_W-1:0] y_addr,
  input  logic               wr_line_done,
  input  logic [LINE_W-1:0]  wr_line,
  output logic               buf_rd_en,
  output logic [ADDR_W-1:0]  buf_rd_addr,
  input  logic [PIX_W-1:0]   buf_rd_data,
  output logic [PIX_W-1:0]   pix_index,
  output logic               pix_valid,
  output logic               underrun
);

  localparam logic [COORD_W-1:0] X_FIRST = COORD_W'(H_OFFSET);
  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(H_OFFSET + ACTIVE_W - 1);
  localparam logic [COORD_W-1:0] Y_END   = COORD_W'(ACTIVE_H);

  state_e                 state_q;
  logic [(1<<LINE_W)-1:0] line_ready_q, line_ready_d;

  logic [LINE_W-1:0]  line;
  logic [COORD_W-1:0] x_rel;
  logic               in_rows, in_cols, at_first, at_last;
  logic               row_ok, fetch;
  pix_tag_t           tag;

  assign line     = y_addr[LINE_W:1];
  assign x_rel    = x_addr - X_FIRST;
  assign in_rows  = (y_addr < Y_END);
  assign in_cols  = (x_addr >= X_FIRST) && (x_addr <= X_LAST);
  assign at_first = in_rows && (x_addr == X_FIRST);
  assign at_last  = in_rows && (x_addr == X_LAST);

  logic unused_x;
  assign unused_x = ^{x_rel[COORD_W-1], x_rel[0]};

  // The first active pixel decides and fetches in the same clock, so it cannot wait for state_q.
  always_comb begin
    row_ok = (state_q == S_FETCH);
    if (at_first) begin
      row_ok = line_ready_q[line];
    end
  end

  assign fetch       = pix_ce && in_rows && in_cols && row_ok;
  assign buf_rd_en   = fetch;
  assign buf_rd_addr = fetch ? buf_addr(line, x_rel[COL_W:1]) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_BLANK;
      underrun <= 1'b0;
    end else if (pix_ce) begin
      if (!in_rows) begin
        state_q <= S_BLANK;
      end else if (at_first) begin
        if (line_ready_q[line]) begin
          state_q <= S_FETCH;
        end else begin
          state_q  <= S_UNDER;
          underrun <= 1'b1;
        end
      end else if (at_last) begin
        state_q <= S_BLANK;
      end
    end
  end

  // Clear after the second (odd) row has shown the line; a same-clock writer set wins.
  always_comb begin
    line_ready_d = line_ready_q;
    if (fetch && at_last && y_addr[0]) begin
      line_ready_d[line] = 1'b0;
    end
    if (wr_line_done) begin
      line_ready_d[wr_line] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line_ready_q <= '0;
    end else begin
      line_ready_q <= line_ready_d;
    end
  end

  assign tag = '{valid: pix_ce, use_ram: fetch, y0: y_addr[0]};

  ppu_line_reader_dly #(
    .RAM_LAT (RAM_LAT),
    .BACKDROP(BACKDROP)
  ) u_dly (
    .clock    (clock),
    .reset    (reset),
    .tag_in   (tag),
    .rd_data  (buf_rd_data),
    .pix_index(pix_index),
    .pix_valid(pix_valid)
  );

endmodule

// File: tb/tb_ppu_line_reader.sv
// Randomised bench for ppu_line_reader with a line-level behavioural model and a few
// hand-computed expectations.
module tb_ppu_line_reader;

  localparam int unsigned RAM_LAT  = 1;
  localparam logic [4:0]  BACKDROP = 5'h00;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pix_ce = 1'b0;
  logic [9:0]  x_addr = '0;
  logic [9:0]  y_addr = '0;
  logic        wr_line_done = 1'b0;
  logic [4:0]  wr_line = '0;
  logic        buf_rd_en;
  logic [12:0] buf_rd_addr;
  logic [4:0]  buf_rd_data = '0;
  logic [4:0]  pix_index;
  logic        pix_valid;
  logic        underrun;

  ppu_line_reader #(
    .RAM_LAT (RAM_LAT),
    .BACKDROP(BACKDROP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .x_addr      (x_addr),
    .y_addr      (y_addr),
    .wr_line_done(wr_line_done),
    .wr_line     (wr_line),
    .buf_rd_en   (buf_rd_en),
    .buf_rd_addr (buf_rd_addr),
    .buf_rd_data (buf_rd_data),
    .pix_index   (pix_index),
    .pix_valid   (pix_valid),
    .underrun    (underrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid  = 0;

  typedef struct {
    int         due;
    logic [4:0] idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t cmp_e;
  bit   m_ready[32];
  bit   m_row_ok = 1'b0;
  bit   m_under  = 1'b0;

  // Buffer contents are a fixed scramble of the address.
  function automatic logic [4:0] mem_val(input logic [12:0] a);
    return a[4:0] ^ a[9:5] ^ {2'b00, a[12:10]} ^ 5'h13;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (buf_rd_en) buf_rd_data <= mem_val(buf_rd_addr);
  end

  // Model of one VGA pixel slot; called after inputs settle, before the DUT samples them.
  task automatic model_step();
    logic [4:0]  line;
    logic [9:0]  xr;
    logic [12:0] a;
    logic [4:0]  d;
    bit          act, fetch;
    exp_t        e;
    check("underrun", 32'(underrun), 32'(m_under));
    line = y_addr[5:1];
    xr   = x_addr - 10'd64;
    a    = {line, xr[8:1]};
    act  = pix_ce && (y_addr < 10'd480) && (x_addr >= 10'd64) && (x_addr < 10'd576);
    if (pix_ce && (y_addr < 10'd480) && (x_addr == 10'd64)) begin
      m_row_ok = m_ready[line];
      if (!m_row_ok) m_under = 1'b1;
    end
    if (pix_ce && (y_addr >= 10'd480)) m_row_ok = 1'b0;
    fetch = act && m_row_ok;
    check("buf_rd_en", 32'(buf_rd_en), 32'(fetch));
    if (fetch) check("buf_rd_addr", 32'(buf_rd_addr), 32'(a));
    if (fetch && (x_addr == 10'd575) && y_addr[0]) m_ready[line] = 1'b0;
    if (wr_line_done) m_ready[wr_line] = 1'b1;
    if (pix_ce) begin
      d = mem_val(a);
`ifdef PPU_LINE_READER_SCANLINES_EN
      if (y_addr[0]) d = {2'b00, d[2:0]};
`endif
      e.due = cyc + int'(RAM_LAT) + 1;
      e.idx = fetch ? d : BACKDROP;
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input bit ce, input logic [9:0] x, input logic [9:0] y, input bit done,
                      input logic [4:0] wl);
    @(negedge clock);
    pix_ce       = ce;
    x_addr       = x;
    y_addr       = y;
    wr_line_done = done;
    wr_line      = wl;
    #1;
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, x_addr, y_addr, 1'b0, 5'd0);
  endtask

  task automatic full_row(input logic [9:0] y);
    for (int x = 0; x < 640; x++) step(1'b1, 10'(x), y, 1'b0, 5'd0);
  endtask

  task automatic run_row(input logic [9:0] y, input int ce_pct, input int done_pct);
    logic [9:0] x;
    bit         ce, done;
    x = '0;
    while (x < 10'd640) begin
      ce   = ($urandom_range(99) < ce_pct);
      done = ($urandom_range(99) < done_pct);
      step(ce, x, y, done, 5'($urandom_range(31)));
      if (ce) x++;
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (pix_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check("pix_valid_spurious", 32'(pix_valid), 32'd0);
        end else begin
          cmp_e = exp_q.pop_front();
          check("pix_latency", 32'(cyc), 32'(cmp_e.due));
          check("pix_index", 32'(pix_index), 32'(cmp_e.idx));
        end
      end else if ((exp_q.size() > 0) && (exp_q[0].due <= cyc)) begin
        check("pix_valid_missing", 32'(pix_valid), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] fetch_addr[4];
    int          v0;
    logic [9:0]  base;
    fetch_addr = '{13'h300, 13'h300, 13'h301, 13'h301};

    repeat (3) @(negedge clock);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_index", 32'(pix_index), 32'(BACKDROP));
    check("rst_buf_rd_en", 32'(buf_rd_en), 32'd0);
    check("rst_buf_rd_addr", 32'(buf_rd_addr), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b1;
    idle(2);

    // Underrun: nothing written, row 0.
    v0 = n_valid;
    full_row(10'd0);
    idle(4);
    check("under_flag", 32'(underrun), 32'd1);
    check("under_count", 32'(n_valid - v0), 32'd640);

    // Fetch: line 3 on row 6.
    step(1'b0, 10'd0, 10'd6, 1'b1, 5'd3);
    for (int x = 0; x < 64; x++) step(1'b1, 10'(x), 10'd6, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 10'(64 + i), 10'd6, 1'b0, 5'd0);
      check("fetch_addr", 32'(buf_rd_addr), 32'(fetch_addr[i]));
      if (i == 2) begin
        check("fetch_echo_valid", 32'(pix_valid), 32'd1);
        check("fetch_echo_index", 32'(pix_index), 32'(mem_val(13'h300)));
      end
    end
    for (int x = 68; x < 640; x++) step(1'b1, 10'(x), 10'd6, 1'b0, 5'd0);
    idle(4);

    // Reset mid-line with reads in flight.
    step(1'b0, 10'd0, 10'd8, 1'b1, 5'd4);
    for (int x = 0; x < 101; x++) step(1'b1, 10'(x), 10'd8, 1'b0, 5'd0);
    @(negedge clock);
    reset        = 1'b0;
    pix_ce       = 1'b0;
    wr_line_done = 1'b0;
    exp_q.delete();
    foreach (m_ready[i]) m_ready[i] = 1'b0;
    m_row_ok = 1'b0;
    m_under  = 1'b0;
    @(negedge clock);
    check("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
    check("mid_rst_pix_index", 32'(pix_index), 32'(BACKDROP));
    check("mid_rst_buf_rd_en", 32'(buf_rd_en), 32'd0);
    check("mid_rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b1;
    idle(2);

    // Consume and wrap: line 31 on rows 62/63, row 64 maps to line 0.
    step(1'b0, 10'd0, 10'd62, 1'b1, 5'd31);
    step(1'b0, 10'd0, 10'd62, 1'b1, 5'd0);
    full_row(10'd62);
    idle(3);
    check("ready31_after_row62", 32'(dut.line_ready_q[31]), 32'd1);
    full_row(10'd63);
    idle(3);
    check("ready31_after_row63", 32'(dut.line_ready_q[31]), 32'd0);
    for (int x = 0; x < 640; x++) begin
      step(1'b1, 10'(x), 10'd64, 1'b0, 5'd0);
      if (x == 64) check("wrap_addr_x64", 32'(buf_rd_addr), 32'h000);
      if (x == 66) check("wrap_addr_x66", 32'(buf_rd_addr), 32'h001);
    end
    idle(3);

    // Set/clear collision on line 5.
    step(1'b0, 10'd0, 10'd10, 1'b1, 5'd5);
    full_row(10'd10);
    for (int x = 0; x < 640; x++) step(1'b1, 10'(x), 10'd11, (x == 575), 5'd5);
    idle(3);
    check("collision_ready5", 32'(dut.line_ready_q[5]), 32'd1);
    full_row(10'd10);
    idle(3);

    // Border and throughput: one pixel per clock across the whole row.
    step(1'b0, 10'd0, 10'd20, 1'b1, 5'd10);
    v0 = n_valid;
    full_row(10'd20);
    idle(4);
    check("throughput_count", 32'(n_valid - v0), 32'd640);

    // Random scan with a loosely paced writer.
    base = 10'($urandom_range(20, 40) * 2);
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(99) < 70) step(1'b0, 10'd0, base + 10'(r), 1'b1, 5'((base + 10'(r)) >> 1));
      run_row(base + 10'(r), int'($urandom_range(40, 100)), 3);
    end
    run_row(10'd478, 70, 5);
    run_row(10'd479, 70, 5);
    run_row(10'd480, 80, 5);
    run_row(10'd500, 80, 5);
    run_row(10'd2, 90, 5);
    idle(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
